adc_seq_ctrl: RTL and testbench

SPI master controller that sequences 16-clock read frames from the 8-bit serial ADC and shares that single ADC between two requesters. It generates `sclk`/`cs_n`, captures the 8 data bits from `sdata`, and returns the sample to the granted requester with a one-cycle valid pulse. It sits between the system-clock user logic and the ADC's SPI pins.

---
 rtl/adc_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: SPI frame sequencer for an 8-bit serial ADC shared by two requesters.
// Each frame holds cs_n_o low for 16 sclk_o periods and captures the data bits
// seen on rising edges 4..11, MSB first. The byte is returned on rdata_o together
// with a one-cycle valid_o pulse, and gnt_o still identifies the owner in that cycle.
// Optional build macro ADC_SEQ_PRIO_EN: fixed priority, where requester 0 always
// wins contention. When it is undefined, arbitration is round-robin.
module adc_seq_ctrl #(
  parameter int unsigned CLK_DIV = 4,  // sclk half-period in clk cycles (2..255)
  parameter int unsigned GAP_HP  = 2   // cs_n high time between frames, in half-periods (1..15)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic [7:0] rdata_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       cs_n_o,
  input  logic       sdata_i
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] GAP_LAST = 5'(GAP_HP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e     state_q, state_d;
  logic [1:0] req_q;
  logic [7:0] div_q, div_d;    // clk cycles within the current half-period
  logic [4:0] edge_q, edge_d;  // rising edges seen in SHIFT; half-periods elapsed in HOLD
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rdata_q, rdata_d;
  logic       valid_q, valid_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic [1:0] win;

`ifdef ADC_SEQ_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    win = req_q[0] ? 2'b01 : {req_q[1], 1'b0};
  end
`else
  logic ptr_q, ptr_d;  // index of the last requester served

  // Round-robin: on contention, the requester not served last wins.
  always_comb begin
    if (req_q == 2'b11) win = ptr_q ? 2'b01 : 2'b10;
    else                win = req_q;
  end

  // The last-served pointer advances only when a grant is issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && req_q != 2'b00) ptr_d = win[1];
  end

  // Pointer register. It resets to requester 1, so requester 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b1;
    else       ptr_q <= ptr_d;
  end
`endif

  // FSM next state and datapath: arbitration, setup delay, the 16-period shift, and the cs_n gap.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    gnt_d   = gnt_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        gnt_d  = 2'b00;
        if (req_q != 2'b00) begin
          gnt_d   = win;
          cs_n_d  = 1'b0;
          div_d   = 8'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          edge_d  = 5'd0;
          shreg_d = 8'h00;
          sclk_d  = 1'b0;  // falling edge 1 opens the first low half
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            // End of a low half: raise sclk, and capture if this is rising edge 4..11.
            sclk_d = 1'b1;
            edge_d = edge_q + 5'd1;
            if (edge_q >= 5'd3 && edge_q <= 5'd10) shreg_d = {shreg_q[6:0], sdata_i};
          end else if (edge_q == 5'd16) begin
            // End of the high half of period 16: close the frame and publish the byte.
            cs_n_d  = 1'b1;
            rdata_d = shreg_q;
            valid_d = 1'b1;
            edge_d  = 5'd0;
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        // gnt stays up through the valid cycle so that valid && gnt[i] marks the owner.
        gnt_d = 2'b00;
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (edge_q == GAP_LAST) state_d = IDLE;
          else                    edge_d  = edge_q + 5'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. sclk and cs_n come straight from flops, so they are glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 2'b00;
      div_q   <= 8'd0;
      edge_q  <= 5'd0;
      shreg_q <= 8'h00;
      rdata_q <= 8'h00;
      valid_q <= 1'b0;
      gnt_q   <= 2'b00;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_i;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);
  assign sclk_o  = sclk_q;
  assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed bench for adc_seq_ctrl at the default parameters,
// with a behavioural ADC on the SPI pins. Honours ADC_SEQ_PRIO_EN when it is defined.
module tb_adc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt_o;
  logic [7:0] rdata_o;
  logic       valid_o, busy_o, sclk_o, cs_n_o;
  logic       sdata = 1'b1;

  int checks = 0;
  int failures = 0;

  // ADC model state
  logic [7:0] adc_fifo[$];
  logic [7:0] adc_byte = 8'h00;
  logic       junk = 1'b1;
  int         fcnt = 0;

  adc_seq_ctrl #(.CLK_DIV(4), .GAP_HP(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .rdata_o(rdata_o),
    .valid_o(valid_o), .busy_o(busy_o), .sclk_o(sclk_o), .cs_n_o(cs_n_o), .sdata_i(sdata)
  );

  always #5 clk = ~clk;

  // ADC: cs_n falling (sclk high) starts a frame. Each sclk fall launches the next bit.
  // The MSB follows falling edge 4. Outside that window the line carries junk.
  always @(negedge sclk_o or negedge cs_n_o) begin
    if (!cs_n_o && sclk_o) begin
      fcnt = 0;
      adc_byte = (adc_fifo.size() > 0) ? adc_fifo.pop_front() : 8'h00;
      junk = ~adc_byte[0];
      sdata = junk;
    end else if (!cs_n_o) begin
      fcnt = fcnt + 1;
      if (fcnt >= 4 && fcnt <= 11) sdata = adc_byte[11 - fcnt];
      else                         sdata = junk;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Step negedges until valid is seen or the bound expires; n = negedges stepped.
  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < bound);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'd0, busy_o}, 32'd0);
  endtask

  logic [1:0] exp_gnt[3];
  logic [7:0] pat[4] = '{8'h80, 8'h01, 8'hFF, 8'h00};

  initial begin
    int n;
    int gnt_bad;
    int extra;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_sclk", {31'd0, sclk_o}, 32'd1);
    check_val("rst_cs_n", {31'd0, cs_n_o}, 32'd1);
    check_val("rst_gnt", {30'd0, gnt_o}, 32'd0);
    check_val("rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_rdata", {24'd0, rdata_o}, 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: latency, frame shape and byte
    adc_fifo.push_back(8'hA5);
    req = 2'b01;
    @(negedge clk);  // after edge 0
    check_val("single_cs_n_edge0", {31'd0, cs_n_o}, 32'd1);
    @(negedge clk);  // after edge 1
    check_val("single_cs_n_edge1", {31'd0, cs_n_o}, 32'd0);
    check_val("single_gnt_edge1", {30'd0, gnt_o}, 32'h1);
    check_val("single_busy", {31'd0, busy_o}, 32'd1);
    n = 1;
    gnt_bad = 0;
    while (!valid_o && n < 300) begin
      @(negedge clk);
      n++;
      if (gnt_o != 2'b01) gnt_bad++;
    end
    check_val("single_latency", n, 133);
    check_val("single_gnt_held", gnt_bad, 0);
    check_val("single_sclk_falls", fcnt, 16);
    check_val("single_rdata", {24'd0, rdata_o}, 32'hA5);
    req = 2'b00;
    @(negedge clk);
    check_val("single_valid_pulse", {31'd0, valid_o}, 32'd0);
    check_val("single_gnt_drop", {30'd0, gnt_o}, 32'd0);
    check_val("single_cs_n_hold", {31'd0, cs_n_o}, 32'd1);
    wait_idle("single_idle");

    // Reset in the middle of SHIFT
    adc_fifo.push_back(8'h66);
    adc_fifo.push_back(8'h99);
    req = 2'b01;
    n = 0;
    while (!(fcnt == 7 && !cs_n_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("rstmid_reached_p7", fcnt, 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstmid_cs_n", {31'd0, cs_n_o}, 32'd1);
    check_val("rstmid_sclk", {31'd0, sclk_o}, 32'd1);
    check_val("rstmid_gnt", {30'd0, gnt_o}, 32'd0);
    check_val("rstmid_rdata", {24'd0, rdata_o}, 32'h00);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_o) extra++;
    end
    check_val("rstmid_no_valid", extra, 0);
    rst = 1'b0;
    wait_valid(300, n);
    check_val("rstmid_fresh_latency", n, 134);
    check_val("rstmid_fresh_rdata", {24'd0, rdata_o}, 32'h99);
    req = 2'b00;
    wait_idle("rstmid_idle");

    // Contention from reset: both held
`ifdef ADC_SEQ_PRIO_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01};
`else
    exp_gnt = '{2'b01, 2'b10, 2'b01};
`endif
    @(negedge clk);
    rst = 1'b1;
    adc_fifo.push_back(8'h3C);
    adc_fifo.push_back(8'hC3);
    adc_fifo.push_back(8'h3C);
    req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_valid(300, n);
      check_val($sformatf("cont%0d_valid", f), {31'd0, valid_o}, 32'd1);
      check_val($sformatf("cont%0d_gnt", f), {30'd0, gnt_o}, {30'd0, exp_gnt[f]});
      check_val($sformatf("cont%0d_rdata", f), {24'd0, rdata_o}, (f == 1) ? 32'hC3 : 32'h3C);
      if (f < 2) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (cs_n_o && n < 50);
        check_val($sformatf("cont%0d_gap", f), n, 9);
      end
    end
    req = 2'b00;
    wait_idle("cont_idle");

    // Pattern integrity on requester 1, junk outside the data window
    foreach (pat[i]) adc_fifo.push_back(pat[i]);
    req = 2'b10;
    for (int f = 0; f < 4; f++) begin
      wait_valid(300, n);
      check_val($sformatf("pat_%02h_gnt", pat[f]), {30'd0, gnt_o}, 32'h2);
      check_val($sformatf("pat_%02h_rdata", pat[f]), {24'd0, rdata_o}, {24'd0, pat[f]});
    end
    req = 2'b00;
    wait_idle("pat_idle");

    // req dropped during SETUP
    adc_fifo.push_back(8'h5A);
    req = 2'b01;
    repeat (3) @(negedge clk);  // after edge 2, in SETUP
    check_val("drop_in_setup", {31'd0, cs_n_o}, 32'd0);
    req = 2'b00;
    wait_valid(300, n);
    check_val("drop_valid", {31'd0, valid_o}, 32'd1);
    check_val("drop_rdata", {24'd0, rdata_o}, 32'h5A);
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid_o) extra++;
    end
    check_val("drop_single_valid", extra, 0);
    check_val("drop_gnt", {30'd0, gnt_o}, 32'd0);
    check_val("drop_busy", {31'd0, busy_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
